// File: rtl/seg_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_display
// Description : Four-digit multiplexed 7-segment driver for an MM:SS
//               stopwatch. One digit is scanned per REFRESH_DIV cycles. A
//               frame-wide snapshot keeps the four digits coherent. In adjust
//               mode the selected pair blinks with a BLINK_DIV half-period.
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous reset, active low
//               m10   - minutes tens digit (3 bits)
//               m1    - minutes ones digit (4 bits)
//               s10   - seconds tens digit (3 bits)
//               s1    - seconds ones digit (4 bits)
//               adj   - adjust mode, enables blinking of the selected pair
//               sel   - pair select: 0 = minutes, 1 = seconds
//               an    - anode enables, active low, an[0] = s1 ... an[3] = m10
//               seg   - segment cathodes, active low, {g,f,e,d,c,b,a}
//               dp    - decimal point, active low, lit as MM.SS separator
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] m10,
  input  logic [3:0] m1,
  input  logic [2:0] s10,
  input  logic [3:0] s1,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_BLANK    = 7'b1111111;

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [13:0]   snap_q, snap_d;           // {m10, m1, s10, s1}
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          scan_tick;
  logic [3:0]    digit_val;
  logic          blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Scan timing, frame snapshot and blink timebase.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    idx_d         = idx_q;
    snap_d        = snap_q;
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;

    scan_tick = (refresh_cnt_q == REFRESH_LAST);
    if (scan_tick) begin
      refresh_cnt_d = '0;
      idx_d         = idx_q + 2'd1;
      // Sample only as the scan wraps so a frame never mixes two counts.
      if (idx_q == 2'd3) begin
        snap_d = {m10, m1, s10, s1};
      end
    end

    // Outside adjust mode the blink state is parked at zero so that entering
    // adjust mode always begins with the digits visible.
    if (adj) begin
      blink_phase_d = blink_phase_q;
      blink_cnt_d   = blink_cnt_q + 1'b1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end
    end
  end

  // Output encoding from the current index, snapshot and blank state.
  always_comb begin
    case (idx_q)
      2'd0:    digit_val = snap_q[3:0];
      2'd1:    digit_val = {1'b0, snap_q[6:4]};
      2'd2:    digit_val = snap_q[10:7];
      default: digit_val = {1'b0, snap_q[13:11]};
    endcase

    // idx_q[1] is set for the minutes pair (indices 2 and 3).
    blank = adj & blink_phase_q & (sel ? ~idx_q[1] : idx_q[1]);

    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : decode(digit_val);
    dp_d  = blank ? 1'b1 : (idx_q != 2'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt_q <= '0;
      idx_q         <= 2'd0;
      snap_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire
